// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and RAM-side signal bundle for mem_arbiter
// slave: the arbiter's view; master: the requesters plus RAM that surround it.
interface mem_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        ihit;
  logic        dhit;
  logic [31:0] iload;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ramready;
  logic        ramerror;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready, ramerror,
    output ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready, ramerror,
    input  ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port RAM arbiter between instruction and data requesters
// ARB_FAIR_EN: when defined, instruction fetches win after DSTARVE_MAX back-to-back data grants.
module mem_arbiter #(
  parameter int DSTARVE_MAX = 4
) (
  input  logic          CLK,
  input  logic          RST,
  mem_arbiter_if.slave  bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] IGRANT = 2'd1;
  localparam logic [1:0] DGRANT = 2'd2;

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       d_req;
  logic       ram_ok;
  logic       ihit;
  logic       dhit;
  logic       i_first;

  assign d_req  = bus.dREN | bus.dWEN;
  assign ram_ok = bus.ramready & ~bus.ramerror;
  assign ihit   = (state_q == IGRANT) & ram_ok;
  assign dhit   = (state_q == DGRANT) & ram_ok;

`ifdef ARB_FAIR_EN
  localparam int CNT_W = ($clog2(DSTARVE_MAX + 1) > 3) ? $clog2(DSTARVE_MAX + 1) : 3;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DSTARVE_MAX);

  logic [CNT_W-1:0] dcnt_q;
  logic [CNT_W-1:0] dcnt_d;

  // Counts data wins only while a fetch is actually waiting.
  always_comb begin
    dcnt_d = dcnt_q;
    if (!bus.iREN || ihit) begin
      dcnt_d = '0;
    end else if (dhit && (dcnt_q != CNT_MAX)) begin
      dcnt_d = dcnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dcnt_q <= '0;
    end else begin
      dcnt_q <= dcnt_d;
    end
  end

  assign i_first = bus.iREN & (dcnt_q == CNT_MAX);
`else
  logic unused_dstarve;
  assign unused_dstarve = (DSTARVE_MAX != 0);
  assign i_first        = 1'b0;
`endif

  // A grant ends on its hit or when its requester withdraws; errors keep it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (d_req && !i_first) begin
          state_d = DGRANT;
        end else if (bus.iREN) begin
          state_d = IGRANT;
        end
      end
      IGRANT: begin
        if (ihit || !bus.iREN) begin
          state_d = IDLE;
        end
      end
      DGRANT: begin
        if (dhit || !d_req) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    case (state_q)
      IGRANT: begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = bus.iaddr;
      end
      DGRANT: begin
        bus.ramREN   = bus.dREN;
        bus.ramWEN   = bus.dWEN;
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
      end
      default: begin
      end
    endcase
  end

  assign bus.ihit  = ihit;
  assign bus.dhit  = dhit;
  assign bus.iload = ihit ? bus.ramload : '0;
  assign bus.dload = dhit ? bus.ramload : '0;

endmodule
